fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter BITNUMBER, default 6, the data word width.
REQ-002 SHALL have parameter DEPTH, default 4, the skid-buffer entry count (power of two, 2..16).
REQ-003 SHALL have ports: clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: enable  input  1  requests draining of the upstream FIFO.
REQ-006 SHALL have ports: fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have ports: fifo_data  input  BITNUMBER  upstream read data, qualified by fifo_valid.
REQ-008 SHALL have ports: fifo_valid  input  1  one pulse per successful upstream read.
REQ-009 SHALL have ports: fifo_rd_error  input  1  one pulse per failed upstream read (read while empty).
REQ-010 SHALL have ports: fifo_rd  output  1  registered upstream pop request.
REQ-011 SHALL have ports: out_data  output  BITNUMBER  skid-buffer head word.
REQ-012 SHALL have ports: out_valid  output  1  head word valid.
REQ-013 SHALL have ports: out_ready  input  1  downstream accepts the head word.
REQ-014 SHALL have ports: busy  output  1  high in READ or DRAIN.
REQ-015 SHALL have ports: proto_err  output  1  sticky protocol violation flag.
REQ-016 SHALL have ports: words_out  output  16  saturating count of words delivered downstream.
REQ-017 SHALL have ports: lost_reads  output  8  saturating count of fifo_rd_error pulses.

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-019 SHALL transition IDLE->READ when enable=1; READ->DRAIN when enable=0; DRAIN->IDLE when outstanding=0; DRAIN->READ when enable=1.
REQ-020 SHALL keep an outstanding-read counter: +1 on each cycle where fifo_rd=1, -1 on each fifo_valid or fifo_rd_error; net change 0 when both occur in one cycle.
REQ-021 SHALL compute credit = DEPTH - occupancy - outstanding, where occupancy is the skid-buffer word count.
REQ-022 SHALL register fifo_rd<=1 for the next cycle only when state=READ, fifo_empty=0 and credit>=2 (credit>=1 when fifo_rd is currently 0); otherwise fifo_rd<=0.
REQ-023 SHALL tolerate any upstream read latency >=1 cycle; each issued read retires by exactly one of fifo_valid or fifo_rd_error.
REQ-024 SHALL write fifo_data into the skid-buffer tail on fifo_valid=1, in arrival order, wrapping the pointer modulo DEPTH.
REQ-025 SHALL drive out_valid=1 whenever occupancy>0 and out_data=head word; out_data SHALL hold its last value when out_valid=0.
REQ-026 SHALL pop the head and increment words_out (saturating at 0xFFFF) when out_valid=1 and out_ready=1.
REQ-027 SHALL perform a push and a pop in the same cycle with occupancy unchanged, including at occupancy=DEPTH.
REQ-028 SHALL increment lost_reads (saturating at 0xFF) on each fifo_rd_error pulse.
REQ-029 SHALL set proto_err and discard the word when fifo_valid=1 with outstanding=0, or when fifo_valid=1 with occupancy=DEPTH and no simultaneous pop.
REQ-030 SHALL also set proto_err on fifo_rd_error with outstanding=0, without decrementing outstanding below 0.
REQ-031 SHALL keep proto_err set until reset.
REQ-032 SHALL keep delivering buffered words downstream in all states, including IDLE.

Reset
REQ-033 SHALL, while reset=1, force state=IDLE, fifo_rd=0, out_valid=0, out_data=0, busy=0, proto_err=0, words_out=0, lost_reads=0, outstanding=0, occupancy=0, and pointers=0.
REQ-034 SHALL discard in-flight reads and buffered words on reset mid-operation; retirements arriving after reset release SHALL set proto_err.

Verification
REQ-035 SHALL verify enable=1, FIFO holding 3 words, latency 2, out_ready=1 -> 3 fifo_rd pulses, words out in order, words_out=3, state back to READ idling with fifo_rd=0.
REQ-036 SHALL verify out_ready=0 with DEPTH=4 and a full FIFO -> exactly 4 reads issued, fifo_rd then held 0, out_valid=1 holding the first word.
REQ-037 SHALL verify fifo_rd_error injected on 2 reads -> lost_reads=2, outstanding returns to 0, no proto_err.
REQ-038 SHALL verify enable dropped with 2 outstanding -> state DRAIN, no new fifo_rd, both words buffered, then IDLE; busy=0.
REQ-039 SHALL verify spurious fifo_valid with outstanding=0 -> proto_err=1 sticky, occupancy unchanged.
REQ-040 SHALL verify reset asserted with 3 words buffered -> next cycle out_valid=0, words_out=0, state=IDLE.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: drains an upstream FIFO into a credit-limited skid buffer with downstream valid/ready
module fifo_reader #(
    parameter int BITNUMBER = 6,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [BITNUMBER-1:0] fifo_data,
    input  logic                 fifo_valid,
    input  logic                 fifo_rd_error,
    output logic                 fifo_rd,
    output logic [BITNUMBER-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 proto_err,
    output logic [15:0]          words_out,
    output logic [7:0]           lost_reads
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = AW + 3;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [BITNUMBER-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]        occupancy, occ_nxt, outstanding;
    logic [UW-1:0]        used;
    logic                 full, pop, push, retire, orphan, overflow, issue;

    // Next state and status; the state only gates new reads, delivery continues in every state
    always_comb begin
        state_nxt = enable ? READ : (state == READ || (state == DRAIN && outstanding != '0)) ? DRAIN : IDLE;
        busy      = state != IDLE;
    end

    // Handshake decode; a read is issued only if every in-flight read is guaranteed a slot
    always_comb begin
        full       = occupancy == CW'(DEPTH);
        out_valid  = occupancy != '0;
        pop        = out_valid && out_ready;
        retire     = (fifo_valid || fifo_rd_error) && outstanding != '0;
        orphan     = (fifo_valid || fifo_rd_error) && outstanding == '0;
        overflow   = fifo_valid && outstanding != '0 && full && !pop;
        push       = fifo_valid && outstanding != '0 && !overflow;
        occ_nxt    = occupancy + CW'(push) - CW'(pop);
        rd_ptr_nxt = rd_ptr + AW'(pop);
        used       = UW'(occupancy) + UW'(outstanding) + (fifo_rd ? UW'(2) : UW'(1));
        issue      = state == READ && !fifo_empty && used <= UW'(DEPTH);
    end

    // State register
    always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;

    // Read issue, credit bookkeeping, buffer pointers, registered head word and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_rd     <= 1'b0;
            outstanding <= '0;
            occupancy   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_data    <= '0;
            proto_err   <= 1'b0;
            words_out   <= '0;
            lost_reads  <= '0;
        end else begin
            fifo_rd     <= issue;
            outstanding <= outstanding + CW'(fifo_rd) - CW'(retire);
            occupancy   <= occ_nxt;
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr_nxt;
            if (occ_nxt != '0)
                out_data <= (push && wr_ptr == rd_ptr_nxt) ? fifo_data : mem[rd_ptr_nxt];
            proto_err   <= proto_err || orphan || overflow;
            words_out   <= words_out + 16'(pop && words_out != 16'hFFFF);
            lost_reads  <= lost_reads + 8'(fifo_rd_error && lost_reads != 8'hFF);
        end
    end

    // Storage array, written only by accepted arrivals
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= fifo_data;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized scoreboard bench with an upstream FIFO model of variable read latency
module tb_fifo_reader;
    localparam int BW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 0, reset = 1, enable = 0, fifo_empty = 1, fifo_valid = 0, fifo_rd_error = 0, out_ready = 0;
    logic [BW-1:0] fifo_data = '0;
    logic          fifo_rd, out_valid, busy, proto_err;
    logic [BW-1:0] out_data;
    logic [15:0]   words_out;
    logic [7:0]    lost_reads;

    typedef struct {int unsigned cyc; bit err; logic [BW-1:0] d;} resp_t;
    resp_t         pend[$];
    logic [BW-1:0] up_q[$], exp_q[$];
    int unsigned   cyc, last_resp;
    int            checks, failures, n_rd, n_err, n_pop, force_err, err_pct, ready_pct, lat_min = 1, lat_max = 1;
    bit            legit_now, retire_now, err_now, spur_v, spur_e;

    always #5 clk = ~clk;

    fifo_reader #(.BITNUMBER(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_valid(fifo_valid), .fifo_rd_error(fifo_rd_error), .fifo_rd(fifo_rd), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .proto_err(proto_err),
        .words_out(words_out), .lost_reads(lost_reads)
    );

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle of the upstream FIFO: accept the visible read, answer due reads, refresh inputs
    task automatic tick();
        resp_t r;
        @(negedge clk);
        cyc++;
        {legit_now, retire_now, err_now, fifo_valid, fifo_rd_error} = '0;
        fifo_data = BW'($urandom);
        if (!reset) begin
            if (fifo_rd) begin
                n_rd++;
                r.cyc = cyc + $urandom_range(lat_max, lat_min);
                if (r.cyc <= last_resp) r.cyc = last_resp + 1;
                r.err = up_q.size() == 0 || force_err > 0 || $urandom_range(99) < err_pct;
                if (force_err > 0) force_err--;
                if (r.err) r.d = '0;
                else r.d = up_q.pop_front();
                last_resp = r.cyc;
                pend.push_back(r);
            end
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                r = pend.pop_front();
                retire_now = 1;
                if (r.err) begin
                    fifo_rd_error = 1; err_now = 1; n_err++;
                end else begin
                    fifo_valid = 1; fifo_data = r.d; legit_now = 1; exp_q.push_back(r.d);
                end
            end else if (spur_v) fifo_valid = 1;
            else if (spur_e) begin
                fifo_rd_error = 1; err_now = 1; n_err++;
            end
        end
        fifo_empty = up_q.size() == 0;
        out_ready  = $urandom_range(99) < ready_pct;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; ready_pct = 0; spur_v = 0; spur_e = 0; err_pct = 0;
        run(2);
        pend.delete(); up_q.delete(); exp_q.delete();
        n_rd = 0; n_err = 0; n_pop = 0; force_err = 0; last_resp = cyc;
        reset = 0;
    endtask

    task automatic fill(int n);
        repeat (n) up_q.push_back(BW'($urandom));
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        enable = 0; ready_pct = 100;
        tick();
        while ((busy || out_valid || fifo_rd || pend.size() > 0) && n < 200) begin
            tick(); n++;
        end
        check({name, "_idle_timeout"}, n < 200, 1);
    endtask

    // Monitor: each cycle compare delivery and counters against the scoreboard
    initial forever begin
        int occ_m;
        @(negedge clk);
        #1;
        if (!reset) begin
            occ_m = exp_q.size() - int'(legit_now);
            check("out_valid", out_valid, occ_m != 0);
            check("credit", pend.size() + retire_now + occ_m <= DEPTH, 1);
            check("words_out", words_out, n_pop);
            check("lost_reads", lost_reads, (n_err - err_now > 255) ? 255 : n_err - err_now);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_data: got unexpected word %0d expected none", out_data);
                end else check("out_data", out_data, exp_q.pop_front());
                n_pop++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] first;
        int n, n0;
        // Reset values
        do_reset();
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_words_out", words_out, 0);
        check("rst_lost_reads", lost_reads, 0);

        // Three words, latency 2, downstream always ready
        lat_min = 2; lat_max = 2; fill(3); ready_pct = 100; enable = 1;
        run(20);
        check("three_rd", n_rd, 3);
        check("three_fifo_rd", fifo_rd, 0);
        check("three_busy", busy, 1);
        check("three_words_out", words_out, 3);

        // Downstream stalled: credit stops reads at DEPTH
        do_reset();
        lat_min = 1; lat_max = 3; fill(8); first = up_q[0]; enable = 1;
        run(25);
        check("full_rd", n_rd, DEPTH);
        check("full_fifo_rd", fifo_rd, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head", out_data, first);
        check("full_proto", proto_err, 0);
        ready_pct = 100;
        run(40);
        check("full_rd_all", n_rd, 8);
        check("full_words_out", words_out, 8);

        // Two failed reads
        do_reset();
        lat_min = 1; lat_max = 4; fill(6); force_err = 2; ready_pct = 100; enable = 1;
        run(40);
        check("err_lost", lost_reads, 2);
        check("err_proto", proto_err, 0);
        check("err_outstanding", pend.size(), 0);
        check("err_rd", n_rd, 8);
        check("err_words_out", words_out, 6);

        // Enable dropped with reads in flight
        do_reset();
        lat_min = 3; lat_max = 3; fill(10); ready_pct = 100; enable = 1;
        n = 0;
        while (pend.size() < 2 && n < 20) begin tick(); n++; end
        check("drain_setup", pend.size() >= 2, 1);
        enable = 0; n0 = n_rd; n = 0;
        while (busy && n < 50) begin tick(); n++; end
        check("drain_idle_timeout", n < 50, 1);
        check("drain_new_rd", n_rd - n0 <= 1, 1);
        check("drain_outstanding", pend.size(), 0);
        check("drain_left", up_q.size() > 0, 1);
        run(3);
        check("drain_fifo_rd", fifo_rd, 0);
        check("drain_delivered", words_out, n_rd);

        // Random traffic
        do_reset();
        lat_min = 1; lat_max = 5; err_pct = 8; ready_pct = 70; enable = 1;
        for (int i = 0; i < 1500; i++) begin
            if (up_q.size() < 6 && $urandom_range(3) == 0) fill($urandom_range(4, 1));
            if ($urandom_range(19) == 0) enable = !enable;
            if ($urandom_range(49) == 0) ready_pct = $urandom_range(4) * 25;
            tick();
        end
        wait_idle("rand");
        check("rand_scoreboard_empty", exp_q.size(), 0);
        check("rand_words_out", words_out, n_pop);
        check("rand_lost", lost_reads, n_err);
        check("rand_proto", proto_err, 0);

        // Spurious arrival sets a sticky protocol error
        spur_v = 1; tick(); spur_v = 0; tick();
        check("spur_proto", proto_err, 1);
        check("spur_occupancy", out_valid, 0);
        run(5);
        check("spur_sticky", proto_err, 1);

        // Failed-read counter saturates
        spur_e = 1; run(300); spur_e = 0; tick();
        check("lost_sat", lost_reads, 255);

        // Reset with words buffered
        do_reset();
        lat_min = 1; lat_max = 2; fill(3); enable = 1;
        run(15);
        check("rstmid_buffered", out_valid, 1);
        reset = 1; tick();
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_words_out", words_out, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_fifo_rd", fifo_rd, 0);
        do_reset();
        check("rstmid_proto", proto_err, 0);
        check("rstmid_lost", lost_reads, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
